sklansky_seq_adder: RTL

- Multi-byte add/subtract sequencer built around one 8-bit `sklansky_adder` instance.
- Holds two WORDS-byte operands in internal byte registers and, on `start`, feeds them through the shared adder one byte per cycle, LSB first, chaining the carry through a register.
- Writes the sum to a result buffer and signals completion with a one-cycle `done` pulse.
- Sits between the board-level operand entry logic (switches/buttons) and the display path, replacing the single-byte store-and-add controller when wider operands are needed.

---
 rtl/sklansky_seq_adder_if.sv | 38 +++
 rtl/sklansky_seq_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_seq_adder_if.sv
// sklansky_seq_adder_if
//   Operand-entry / control / result bus for sklansky_seq_adder.
//   master: board-side entry and display logic (drives writes, start, reads).
//   slave : the sequencer.
//   Signals:
//     wr_en/wr_sel/wr_addr/wr_data : operand byte write (sel 0 = A, 1 = B)
//     start/sub/cin                : operation request, sampled in IDLE
//     rd_addr/rd_data              : combinational result byte read
//     busy/done/cout/ovf           : status
interface sklansky_seq_adder_if #(
  parameter int WORDS = 4
);
  localparam int AW = $clog2(WORDS);

  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          sub;
  logic          cin;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          cout;
  logic          ovf;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, sub, cin, rd_addr,
    input  rd_data, busy, done, cout, ovf
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, sub, cin, rd_addr,
    output rd_data, busy, done, cout, ovf
  );
endinterface

// File: rtl/sklansky_seq_adder.sv
// sklansky_seq_adder
//   Multi-byte add/subtract sequencer. Two WORDS-byte operands are held in
//   byte registers; on start they are streamed LSB first through one 8-bit
//   Sklansky prefix adder, one byte per cycle, with the carry chained
//   through a register. The sum lands in a result buffer, done pulses once.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : sklansky_seq_adder_if.slave (operand writes, start/sub/cin,
//            rd_addr -> rd_data, busy/done/cout/ovf)
//   Build option:
//     SKLANSKY_SEQ_OVF_EN : when defined, ovf is computed and registered;
//                           otherwise ovf is tied to 0.

// Prefix combine cell: (g,p) = (g_hi,p_hi) o (g_lo,p_lo)
module sklansky_pg_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// 8-bit Sklansky (divide-and-conquer) prefix adder, purely combinational.
module sklansky_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  localparam int W   = 8;
  localparam int LVL = 3;

  // gl[l][i]/pl[l][i]: group generate/propagate of bit i after l levels
  logic [W-1:0] gl [LVL+1];
  logic [W-1:0] pl [LVL+1];
  logic [W:0]   c;

  assign gl[0] = a & b;
  assign pl[0] = a ^ b;

  genvar l, i;
  generate
    for (l = 0; l < LVL; l++) begin : g_lvl
      for (i = 0; i < W; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_cell
          // combine with the top bit of the lower half of this block
          localparam int J = ((i >> l) << l) - 1;
          sklansky_pg_cell u_cell (
            .g_hi (gl[l][i]),
            .p_hi (pl[l][i]),
            .g_lo (gl[l][J]),
            .p_lo (pl[l][J]),
            .g    (gl[l+1][i]),
            .p    (pl[l+1][i])
          );
        end else begin : g_pass
          assign gl[l+1][i] = gl[l][i];
          assign pl[l+1][i] = pl[l][i];
        end
      end
    end

    // fold carry-in after the prefix tree: c[i+1] = G[i:0] | P[i:0]&ci
    assign c[0] = ci;
    for (i = 0; i < W; i++) begin : g_carry
      assign c[i+1] = gl[LVL][i] | (pl[LVL][i] & ci);
    end
  endgenerate

  assign s  = pl[0] ^ c[W-1:0];
  assign co = c[W];
endmodule

module sklansky_seq_adder #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sklansky_seq_adder_if.slave  bus
);
  localparam int AW = $clog2(WORDS);
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WORDS-1:0][7:0] a_reg;
  logic [WORDS-1:0][7:0] b_reg;
  logic [WORDS-1:0][7:0] r_reg;
  logic [AW-1:0]         idx;
  logic                  carry;
  logic                  op_sub;
  logic                  busy_r;
  logic                  done_r;
  logic                  cout_r;

  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_s;
  logic       add_co;
  logic       wr_ok;
  logic       rd_ok;
  logic       wr_fire;
  logic       last;

  // Non-power-of-two WORDS leaves unused address codes: drop those writes
  // and read them back as zero.
  generate
    if ((1 << AW) == WORDS) begin : g_pow2
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_npow2
      assign wr_ok = (int'(bus.wr_addr) < WORDS);
      assign rd_ok = (int'(bus.rd_addr) < WORDS);
    end
  endgenerate

  // Operands are read in ADD, so a write in the start cycle is already
  // visible to byte 0.
  assign add_a = a_reg[idx];
  assign add_b = op_sub ? ~b_reg[idx] : b_reg[idx];
  assign last  = (idx == LAST);

  sklansky_adder u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ADD;
      ADD:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operands frozen while the sequencer walks them
  assign wr_fire = bus.wr_en && (state != ADD) && wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      op_sub <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == ADD);
      done_r <= (state_nxt == DONE);

      if (state == IDLE && bus.start) begin
        op_sub <= bus.sub;
        idx    <= '0;
        // subtract = A + ~B + 1
        carry  <= bus.sub ? 1'b1 : bus.cin;
      end

      if (state == ADD) begin
        r_reg[idx] <= add_s;
        carry      <= add_co;
        if (last) cout_r <= add_co;
        else      idx    <= idx + 1'b1;
      end

      if (wr_fire) begin
        if (bus.wr_sel) b_reg[bus.wr_addr] <= bus.wr_data;
        else            a_reg[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

`ifdef SKLANSKY_SEQ_OVF_EN
  logic ovf_r;
  // signed overflow: like-signed MSB operands whose sum sign differs
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == ADD && last) begin
      ovf_r <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
    end
  end
  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.rd_data = rd_ok ? r_reg[bus.rd_addr] : 8'h00;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.cout    = cout_r;
endmodule
